// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_OWN = 1'b1} arb_state_t;

  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [SEL_W-1:0]   sel_t;

  function automatic req_vec_t onehot(input sel_t s);
    return req_vec_t'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority pick: first requester at or after ptr,
// wrapping modulo 4, skipping any bit set in excl.
module rr_pick4
  import arb_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  input  req_vec_t excl,
  output logic     valid,
  output sel_t     idx
);

  sel_t cand;

  // Scan farthest offset first so the nearest eligible requester wins last.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand] && !excl[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for four level requesters with registered one-hot grant
// and encoded select. Define ARB_HOLD_LIMIT_EN to enable forced rotation.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  req_vec_t   req,
  output req_vec_t   grant,
  output sel_t       sel,
  output logic       busy,
  output arb_state_t dbg_state
);

  if (HOLD_LIMIT < 2 || HOLD_LIMIT > 255) begin : g_bad_limit
    $error("rr_arbiter4: HOLD_LIMIT out of range 2..255");
  end

  // Handshake: req is a level; requester i owns the resource while
  // grant[i]=1 and releases it by dropping req[i]. No other handshake exists.

  arb_state_t state;
  sel_t       ptr;
  req_vec_t   excl;
  logic       preempt;
  logic       pick_valid;
  sel_t       pick_idx;
  logic       take_new;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(HOLD_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_LIMIT - 1);

  logic [CNT_W-1:0] hold_cnt;

  assign preempt = (state == ARB_OWN) && (hold_cnt == CNT_LAST) && |(req & ~grant);
  assign excl    = (state == ARB_OWN) ? grant : '0;

  // Counts cycles of the current ownership; saturates so a late competitor
  // preempts immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (take_new || state == ARB_IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt != CNT_LAST) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign preempt = 1'b0;
  assign excl    = '0;
`endif

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .excl  (excl),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign take_new = pick_valid && (state == ARB_IDLE || !req[sel] || preempt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      grant <= '0;
      sel   <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
    end else begin
      if (take_new) begin
        state <= ARB_OWN;
        grant <= onehot(pick_idx);
        sel   <= pick_idx;
        busy  <= 1'b1;
        ptr   <= pick_idx + 1'b1;
      end else if (state == ARB_OWN && !req[sel]) begin
        // Owner released with nobody waiting; sel keeps the last index.
        state <= ARB_IDLE;
        grant <= '0;
        busy  <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomized and directed bench for rr_arbiter4 against an integer-level
// round-robin reference model.
module tb_rr_arbiter4;
  import arb_pkg::*;

  localparam int HL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  req_vec_t   req = '0;
  req_vec_t   grant;
  sel_t       sel;
  logic       busy;
  arb_state_t dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_cnt   = 0;
  int   m_sel   = 0;
  logic [7:0] exp_q[$];

  rr_arbiter4 #(.HOLD_LIMIT(HL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p, input int skip);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i] && i != skip) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rst);
    int  w;
    bit  pre;
    logic [3:0] g;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      w = pick(r, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_cnt = 0;
      end
    end else begin
      pre = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      pre = (m_cnt == HL - 1) && ((r & ~(4'b0001 << m_owner)) != 4'b0000);
`endif
      if (r[m_owner] && !pre) begin
        if (m_cnt < HL - 1) m_cnt++;
      end else begin
        w = pick(r, m_ptr, m_owner);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_cnt = 0;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end
    end
    g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    exp_q.push_back({g, 2'(m_sel), (m_owner >= 0), (m_owner >= 0)});
  endtask

  task automatic check_outputs();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 8'd1, 8'd0);
      return;
    end
    e = exp_q.pop_front();
    check_val("grant", 8'(grant), 8'(e[7:4]));
    check_val("sel",   8'(sel),   8'(e[3:2]));
    check_val("busy",  8'(busy),  8'(e[1]));
    check_val("state", 8'(dbg_state), 8'(e[0]));
    if (busy) check_val("grant_vs_sel", 8'(grant), 8'(4'b0001 << sel));
  endtask

  // Drive one cycle: inputs change on the falling edge, outputs checked 1
  // time unit after the rising edge.
  task automatic step(input logic [3:0] r, input logic rst);
    @(negedge clk);
    req   = r;
    reset = rst;
    @(posedge clk);
    model_step(r, rst);
    #1;
    check_outputs();
  endtask

  logic [3:0] rr;

  initial begin
    // reset with all requests high
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    check_val("rst_grant", 8'(grant), 8'h00);
    step(4'b1111, 1'b0);
    check_val("first_grant", 8'(grant), 8'h01);

    // each owner drops for one cycle in turn
    step(4'b1111, 1'b0);
    step(4'b1110, 1'b0);
    check_val("rot1", 8'(grant), 8'h02);
    step(4'b1101, 1'b0);
    check_val("rot2", 8'(grant), 8'h04);
    step(4'b1011, 1'b0);
    check_val("rot3", 8'(grant), 8'h08);
    step(4'b0111, 1'b0);
    check_val("rot0", 8'(grant), 8'h01);

    // single requester, then release
    step(4'b0000, 1'b1);
    step(4'b0100, 1'b0);
    check_val("solo_sel", 8'(sel), 8'd2);
    step(4'b0000, 1'b0);
    check_val("idle_sel_hold", 8'(sel), 8'd2);
    check_val("idle_busy", 8'(busy), 8'd0);

    // owner 1 holds against 3; on release ptr=2 picks 3 before 0
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b1010, 1'b0);
    check_val("hold1", 8'(grant), 8'h02);
    step(4'b1001, 1'b0);
    check_val("skip_to3", 8'(grant), 8'h08);

    // reset mid-grant, ptr returns to 0
    step(4'b1001, 1'b1);
    check_val("rst_mid", 8'(grant), 8'h00);
    step(4'b1001, 1'b0);
    check_val("post_rst", 8'(grant), 8'h01);

`ifdef ARB_HOLD_LIMIT_EN
    step(4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) step(4'b0011, 1'b0);
    for (int i = 0; i < 12; i++) step(4'b0001, 1'b0);
`endif

    // random sticky requests with occasional reset
    rr = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) rr[b] = ~rr[b];
      step(rr, ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
